// File: rtl/fetch_buffer_pkg.sv
// Shared types and constants for the fetch-to-decode instruction buffer.
// A buffered entry is a fetched PC together with the instruction word read at it.
package fetch_buffer_pkg;

  localparam int FETCH_BUF_DEPTH = 4;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage : fetch_buffer_pkg

// File: rtl/fetch_buffer.sv
// Decouples instruction fetch from decode with a small FIFO of {pc, instr} entries.
// A fetch redirect (flush) empties the buffer and drops whatever is presented in that cycle.
module fetch_buffer
  import fetch_buffer_pkg::*;
#(
  parameter int DEPTH = FETCH_BUF_DEPTH
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       valid_F,
  input  logic [63:0]                pc_F,
  input  logic [31:0]                instr_F,
  output logic                       ready_F,
  output logic                       valid_D,
  output logic [63:0]                pc_D,
  output logic [31:0]                instr_D,
  input  logic                       ready_D,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  fetch_entry_t             mem_q [DEPTH];
  fetch_entry_t             mem_d [DEPTH];
  logic         [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic         [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic         [CNT_W-1:0] count_q, count_d;
  logic                     push_s;
  logic                     pop_s;
  fetch_entry_t             head_s;

  // Handshakes are qualified only by registered state, so ready_F never depends on ready_D.
  always_comb begin
    ready_F = (count_q < CNT_W'(DEPTH)) && !reset;
    valid_D = (count_q != CNT_W'(0));
    push_s  = valid_F && ready_F && !flush && !reset;
    pop_s   = valid_D && ready_D && !flush && !reset;
    head_s  = mem_q[rd_ptr_q];
    if (valid_D) begin
      pc_D    = head_s.pc;
      instr_D = head_s.instr;
    end else begin
      pc_D    = 64'd0;
      instr_D = 32'd0;
    end
    count = count_q;
  end

  // Next-state for storage, pointers and occupancy; pointers wrap naturally as DEPTH is a power of 2.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = '{pc: pc_F, instr: instr_F};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      count_d = count_d;
    end
  end

  // Control state register; reset wins over everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage is not reset: its contents are never visible while the buffer is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule : fetch_buffer

// File: tb/tb_fetch_buffer.sv
// Directed self-checking bench for fetch_buffer with hand-computed expectations.
module tb_fetch_buffer;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             flush;
  logic             valid_F;
  logic [63:0]      pc_F;
  logic [31:0]      instr_F;
  logic             ready_F;
  logic             valid_D;
  logic [63:0]      pc_D;
  logic [31:0]      instr_D;
  logic             ready_D;
  logic [CNT_W-1:0] count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fetch_buffer #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .valid_F (valid_F),
    .pc_F    (pc_F),
    .instr_F (instr_F),
    .ready_F (ready_F),
    .valid_D (valid_D),
    .pc_D    (pc_D),
    .instr_D (instr_D),
    .ready_D (ready_D),
    .count   (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset   = 1'b1;
    flush   = 1'b0;
    valid_F = 1'b1;
    pc_F    = 64'd100;
    instr_F = 32'hDEAD_0000;
    ready_D = 1'b0;

    // Reset held 5 cycles with valid_F asserted.
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("rst_ready_F", ready_F, 64'd0);
      chk("rst_valid_D", valid_D, 64'd0);
      chk("rst_count",   count,   64'd0);
      chk("rst_pc_D",    pc_D,    64'd0);
      chk("rst_instr_D", instr_D, 64'd0);
    end
    reset   = 1'b0;
    valid_F = 1'b0;
    #1;
    chk("post_rst_ready_F", ready_F, 64'd1);

    // Fill PCs 0,4,8,12 with decode stalled.
    for (int i = 0; i < 4; i++) begin
      valid_F = 1'b1;
      pc_F    = 64'(4 * i);
      instr_F = 32'h1000 + 32'(i);
      tick();
      chk("fill_count", count, 64'(i + 1));
      chk("fill_head",  pc_D,  64'd0);
    end
    chk("full_ready_F", ready_F, 64'd0);
    chk("full_count",   count,   64'd4);

    // Fifth push refused.
    pc_F    = 64'd16;
    instr_F = 32'h1004;
    tick();
    chk("over_count", count, 64'd4);
    chk("over_head",  pc_D,  64'd0);
    chk("over_instr", instr_D, 64'h1000);

    // Drain from full while fetch still offers PC 16: the pop frees a slot only next cycle.
    ready_D = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_pc",    pc_D,    64'(4 * i));
      chk("drain_instr", instr_D, 64'(32'h1000 + 32'(i)));
      if (i == 0) begin
        chk("drain_full_ready_F", ready_F, 64'd0);
      end
      valid_F = 1'b0;
      tick();
      chk("drain_count", count, 64'(3 - i));
    end
    chk("empty_valid_D", valid_D, 64'd0);
    chk("empty_instr_D", instr_D, 64'd0);
    chk("empty_pc_D",    pc_D,    64'd0);
    tick();
    chk("empty_pop_count", count, 64'd0);

    // Streaming: first push lands, then push+pop every cycle across pointer wrap.
    valid_F = 1'b1;
    pc_F    = 64'd0;
    instr_F = 32'h2000;
    tick();
    chk("stream_first_count", count, 64'd1);
    chk("stream_first_pc",    pc_D,  64'd0);
    for (int k = 1; k <= 10; k++) begin
      pc_F    = 64'(4 * k);
      instr_F = 32'h2000 + 32'(k);
      tick();
      chk("stream_count", count,   64'd1);
      chk("stream_pc",    pc_D,    64'(4 * k));
      chk("stream_instr", instr_D, 64'(32'h2000 + 32'(k)));
    end
    valid_F = 1'b0;
    tick();
    chk("stream_end_count", count, 64'd0);

    // Flush with count=3 while PC 16 is presented.
    ready_D = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_F = 1'b1;
      pc_F    = 64'(100 + 4 * i);
      instr_F = 32'h3000 + 32'(i);
      tick();
    end
    chk("pre_flush_count", count, 64'd3);
    flush   = 1'b1;
    pc_F    = 64'd16;
    instr_F = 32'h3016;
    ready_D = 1'b1;
    tick();
    flush   = 1'b0;
    valid_F = 1'b0;
    ready_D = 1'b0;
    #1;
    chk("flush_count",   count,   64'd0);
    chk("flush_valid_D", valid_D, 64'd0);
    valid_F = 1'b1;
    pc_F    = 64'd200;
    instr_F = 32'h3200;
    tick();
    valid_F = 1'b0;
    chk("post_flush_pc",    pc_D,  64'd200);
    chk("post_flush_count", count, 64'd1);
    ready_D = 1'b1;
    tick();
    ready_D = 1'b0;

    // Reset mid-operation with push, pop and flush all active.
    for (int i = 0; i < 2; i++) begin
      valid_F = 1'b1;
      pc_F    = 64'(300 + 4 * i);
      instr_F = 32'h4000 + 32'(i);
      tick();
    end
    chk("pre_rst_count", count, 64'd2);
    reset   = 1'b1;
    flush   = 1'b1;
    ready_D = 1'b1;
    pc_F    = 64'd308;
    tick();
    chk("midrst_count",   count,   64'd0);
    chk("midrst_valid_D", valid_D, 64'd0);
    chk("midrst_pc_D",    pc_D,    64'd0);
    chk("midrst_ready_F", ready_F, 64'd0);
    reset   = 1'b0;
    flush   = 1'b0;
    valid_F = 1'b0;
    ready_D = 1'b0;
    #1;
    chk("midrst_release_ready_F", ready_F, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fetch_buffer
